// File: rtl/config_ctrl_if.sv
// Command/response handshake bundle between a host and config_ctrl.
// The packet width is derived here so host and controller always agree on it.
interface config_ctrl_if #(
    parameter int CAW = 15,
    parameter int CDW = 21
);
    localparam int PW = 1 + CAW + CDW;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [PW-1:0]        cmd_data;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [CAW+CDW-1:0]   rsp_data;

    modport master (
        output cmd_valid, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/config_ctrl.sv
// Single-outstanding command controller that turns host packets into
// one-cycle configurator write/read strobes and returns read responses.
module config_ctrl #(
    parameter int CDW = 21,
    parameter int CAW = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    config_ctrl_if.slave      bus,
    output logic              config_we,
    output logic [CAW-1:0]    config_waddr,
    output logic [CDW-1:0]    config_wdata,
    output logic              config_re,
    output logic [CAW-1:0]    config_raddr,
    input  logic [CDW-1:0]    config_rdata,
    output logic              busy
);
    localparam int PW = 1 + CAW + CDW;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        RSP  = 3'd4
    } state_t;

    state_t               state;
    state_t               next_state;
    logic                 accept;
    logic [CAW-1:0]       cmd_addr;
    logic [CDW-1:0]       cmd_wdata;
    logic [CAW+CDW-1:0]   rsp_q;

    assign accept = bus.cmd_ready && bus.cmd_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state is defaulted before the case so no path through the
    // block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (bus.cmd_valid) next_state = bus.cmd_data[PW-1] ? WR : RD;
            WR:   next_state = IDLE;
            RD:   next_state = CAP;
            CAP:  next_state = RSP;
            RSP:  if (bus.rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Moore outputs: strobes and handshakes depend on state alone.
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        config_we     = 1'b0;
        config_re     = 1'b0;
        busy          = 1'b1;
        unique case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                busy          = 1'b0;
            end
            WR:   config_we     = 1'b1;
            RD:   config_re     = 1'b1;
            CAP:  ;
            RSP:  bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Both fields are captured on every accept; reads simply ignore the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (accept) begin
            cmd_addr  <= bus.cmd_data[PW-2:CDW];
            cmd_wdata <= bus.cmd_data[CDW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q <= '0;
        end else if (state == CAP) begin
            rsp_q <= {cmd_addr, config_rdata};
        end
    end

    assign config_waddr = cmd_addr;
    assign config_raddr = cmd_addr;
    assign config_wdata = cmd_wdata;
    assign bus.rsp_data = rsp_q;

    a_strobes_exclusive : assert property (
        @(posedge clk) disable iff (!rst_n) !(config_we && config_re));

    a_rsp_held : assert property (
        @(posedge clk) disable iff (!rst_n)
        (bus.rsp_valid && !bus.rsp_ready) |=> (bus.rsp_valid && $stable(bus.rsp_data)));

    a_we_single : assert property (
        @(posedge clk) disable iff (!rst_n) config_we |=> !config_we);
endmodule

// File: tb/tb_config_ctrl.sv
// Directed bench for config_ctrl with a small configurator responder model.
module tb_config_ctrl;
    localparam int CAW = 15;
    localparam int CDW = 21;

    typedef struct {
        logic           op;
        logic [CAW-1:0] addr;
        logic [CDW-1:0] data;
        logic [CDW-1:0] rdata;
    } vec_t;

    logic           clk;
    logic           rst_n;
    logic           config_we;
    logic [CAW-1:0] config_waddr;
    logic [CDW-1:0] config_wdata;
    logic           config_re;
    logic [CAW-1:0] config_raddr;
    logic [CDW-1:0] config_rdata = '0;
    logic           busy;

    int tests = 0;
    int failed = 0;
    int we_pulses = 0;

    logic [CDW-1:0] mem [16] = '{default: '0};

    vec_t vecs [9];
    vec_t stream [4];

    config_ctrl_if #(.CAW(CAW), .CDW(CDW)) bus ();

    config_ctrl #(.CDW(CDW), .CAW(CAW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .config_we    (config_we),
        .config_waddr (config_waddr),
        .config_wdata (config_wdata),
        .config_re    (config_re),
        .config_raddr (config_raddr),
        .config_rdata (config_rdata),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Configurator: type 3'b111 is unmapped and returns a fixed pattern.
    always @(posedge clk) begin
        if (config_we && config_waddr[CAW-1:CAW-3] != 3'b111)
            mem[config_waddr[3:0]] <= config_wdata;
        if (config_re)
            config_rdata <= (config_raddr[CAW-1:CAW-3] == 3'b111) ? 21'h1EEEEE
                                                                  : mem[config_raddr[3:0]];
        if (config_we)
            we_pulses <= we_pulses + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge while the DUT is in IDLE; returns in IDLE.
    task automatic apply_vec(input vec_t v);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = {v.op, v.addr, v.data};
        check("idle_ready", 64'(bus.cmd_ready), 64'(1'b1));
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (v.op) begin
            check("wr_we", 64'(config_we), 64'(1'b1));
            check("wr_waddr", 64'(config_waddr), 64'(v.addr));
            check("wr_wdata", 64'(config_wdata), 64'(v.data));
            check("wr_re_low", 64'(config_re), 64'(1'b0));
            check("wr_not_ready", 64'(bus.cmd_ready), 64'(1'b0));
            @(negedge clk);
            check("wr_we_done", 64'(config_we), 64'(1'b0));
            check("wr_back_idle", 64'(bus.cmd_ready), 64'(1'b1));
        end else begin
            check("rd_re", 64'(config_re), 64'(1'b1));
            check("rd_raddr", 64'(config_raddr), 64'(v.addr));
            check("rd_we_low", 64'(config_we), 64'(1'b0));
            check("rd_no_rsp", 64'(bus.rsp_valid), 64'(1'b0));
            @(negedge clk);
            check("cap_re_low", 64'(config_re), 64'(1'b0));
            check("cap_no_rsp", 64'(bus.rsp_valid), 64'(1'b0));
            @(negedge clk);
            check("rsp_valid", 64'(bus.rsp_valid), 64'(1'b1));
            check("rsp_data", 64'(bus.rsp_data), 64'({v.addr, v.rdata}));
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            check("rsp_done", 64'(bus.rsp_valid), 64'(1'b0));
            check("rsp_back_idle", 64'(bus.cmd_ready), 64'(1'b1));
            bus.rsp_ready = 1'b0;
        end
    endtask

    initial begin
        int base;

        vecs[0] = '{1'b1, 15'h0001, 21'h00040,  21'h0};
        vecs[1] = '{1'b0, 15'h0001, 21'h0,      21'h00040};
        vecs[2] = '{1'b1, 15'h0002, 21'h1ABCD,  21'h0};
        vecs[3] = '{1'b1, 15'h2005, 21'h00123,  21'h0};
        vecs[4] = '{1'b0, 15'h2005, 21'h1FFFF,  21'h00123};
        vecs[5] = '{1'b0, 15'h0002, 21'h0,      21'h1ABCD};
        vecs[6] = '{1'b1, 15'h7FFF, 21'h1FFFFF, 21'h0};
        vecs[7] = '{1'b0, 15'h7000, 21'h0,      21'h1EEEEE};
        vecs[8] = '{1'b0, 15'h0003, 21'h0,      21'h00007};

        stream[0] = '{1'b1, 15'h0006, 21'h11111, 21'h0};
        stream[1] = '{1'b1, 15'h0007, 21'h02222, 21'h0};
        stream[2] = '{1'b1, 15'h0008, 21'h13333, 21'h0};
        stream[3] = '{1'b1, 15'h0009, 21'h04444, 21'h0};

        // Reset with a write already presented; it must go on the first edge after release.
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = {1'b1, 15'h0003, 21'h00007};
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1'b1));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
        check("rst_we", 64'(config_we), 64'(1'b0));
        check("rst_re", 64'(config_re), 64'(1'b0));
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_waddr", 64'(config_waddr), 64'(15'h0));
        check("rst_wdata", 64'(config_wdata), 64'(21'h0));
        check("rst_rsp_data", 64'(bus.rsp_data), 64'(36'h0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_we", 64'(config_we), 64'(1'b1));
        check("first_waddr", 64'(config_waddr), 64'(15'h0003));
        check("first_wdata", 64'(config_wdata), 64'(21'h00007));
        check("first_busy", 64'(busy), 64'(1'b1));
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("first_idle", 64'(bus.cmd_ready), 64'(1'b1));

        for (int i = 0; i < 9; i++) apply_vec(vecs[i]);

        // Response stall with a write held pending behind it.
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = {1'b0, 15'h0001, 21'h0};
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = {1'b1, 15'h0004, 21'h0ABCD};
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 64'(bus.rsp_valid), 64'(1'b1));
            check("stall_data", 64'(bus.rsp_data), 64'({15'h0001, 21'h00040}));
            check("stall_not_ready", 64'(bus.cmd_ready), 64'(1'b0));
            check("stall_no_we", 64'(config_we), 64'(1'b0));
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        check("stall_still_valid", 64'(bus.rsp_valid), 64'(1'b1));
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("stall_done", 64'(bus.rsp_valid), 64'(1'b0));
        check("stall_idle", 64'(bus.cmd_ready), 64'(1'b1));
        check("pending_not_yet", 64'(config_we), 64'(1'b0));
        @(negedge clk);
        check("pending_we", 64'(config_we), 64'(1'b1));
        check("pending_waddr", 64'(config_waddr), 64'(15'h0004));
        check("pending_wdata", 64'(config_wdata), 64'(21'h0ABCD));
        bus.cmd_valid = 1'b0;
        @(negedge clk);

        // Back-to-back writes with cmd_valid held high throughout.
        base = we_pulses;
        for (int i = 0; i < 4; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_data  = {stream[i].op, stream[i].addr, stream[i].data};
            check("stream_ready", 64'(bus.cmd_ready), 64'(1'b1));
            @(negedge clk);
            check("stream_we", 64'(config_we), 64'(1'b1));
            check("stream_waddr", 64'(config_waddr), 64'(stream[i].addr));
            check("stream_wdata", 64'(config_wdata), 64'(stream[i].data));
            check("stream_busy", 64'(bus.cmd_ready), 64'(1'b0));
            @(negedge clk);
            check("stream_we_low", 64'(config_we), 64'(1'b0));
        end
        bus.cmd_valid = 1'b0;
        check("stream_pulses", 64'(we_pulses - base), 64'(4));
        apply_vec('{1'b0, 15'h0008, 21'h0, 21'h13333});

        // Reset pulse while a response is pending.
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = {1'b0, 15'h0002, 21'h0};
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_rsp", 64'(bus.rsp_valid), 64'(1'b1));
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", 64'(bus.rsp_valid), 64'(1'b0));
        check("abort_busy", 64'(busy), 64'(1'b0));
        check("abort_ready", 64'(bus.cmd_ready), 64'(1'b1));
        check("abort_raddr", 64'(config_raddr), 64'(15'h0));
        check("abort_rsp_data", 64'(bus.rsp_data), 64'(36'h0));
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_replay_valid", 64'(bus.rsp_valid), 64'(1'b0));
            check("no_replay_busy", 64'(busy), 64'(1'b0));
        end
        bus.rsp_ready = 1'b0;
        apply_vec('{1'b0, 15'h0001, 21'h0, 21'h00040});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end
endmodule
